alu_logic_seq: RTL and testbench
================================

# alu_logic_seq

Parametrised, multi-cycle bitwise logic unit that supersedes the single-function combinational `alu_and`. It processes operands `CHUNK` bits per cycle under a three-state FSM and supports four selectable operations. Handshakes are valid/ready on both sides, so it can sit between the register-read stage and the writeback buffer in the ALU datapath.

## Interface
- `WIDTH`, 32, operand and result width in bits. Must be a multiple of `CHUNK`.
- `CHUNK`, 8, bits processed per BUSY cycle. `N = WIDTH/CHUNK` beats per operation.
- `clk  input  1`: clock, rising-edge active.
- `rst  input  1`: reset, synchronous and active-high.
- `in_valid  input  1`: request valid.
- `in_ready  output  1`: unit can accept a request. High only in IDLE.
- `op  input  2`: operation select. 00 AND, 01 OR, 10 XOR, 11 NOR.
- `rs1  input  WIDTH`: operand 1.
- `rs2  input  WIDTH`: operand 2.
- `out_valid  output  1`: `rd` holds a completed result. High only in DONE.
- `out_ready  input  1`: consumer accepts the result.
- `rd  output  WIDTH`: result register.
- `zero  output  1`: result is all zeros. Present only with `ALU_LOGIC_ZFLAG_EN`.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: capture `rs1`, `rs2` and `op` into internal registers, clear beat counter `cnt`, and go to BUSY.
  - Input changes after capture are ignored.
- **BUSY**
  - Each cycle computes beat `cnt`: bits `[cnt*CHUNK +: CHUNK]` of the captured operands under the captured op, written into the accumulator. Beats run LSB-first.
  - `cnt` increments each cycle.
  - On the beat with `cnt==N-1`: load `rd` from the accumulator with the final beat merged in, then go to DONE.
- **DONE**
  - `out_valid`=1. `rd` (and `zero`) are held stable.
  - On `out_ready`=1: go to IDLE.
  - `out_ready` may be tied high.
- **`rd` update rule:** `rd` changes only on the BUSY→DONE transition. It keeps the previous result through IDLE and BUSY.
- **NOR:** `~(a|b)`, computed per chunk. No carries and no cross-chunk dependence.
- **`cnt` width:** `$clog2(N)`, minimum 1 bit.
- **`CHUNK==WIDTH` (N=1):** BUSY lasts exactly one cycle.
- **`in_valid` outside IDLE:** ignored. `in_ready`=0, so no capture occurs.
- **Simultaneous events:** none possible. Capture occurs only in IDLE and completion only in DONE, and the states are disjoint.
- **Reset (any state, including mid-BUSY):** on the next rising edge:
  - state=IDLE, `cnt`=0, accumulator=0, `rd`=0;
  - `out_valid`=0, `in_ready`=1, `zero`=1;
  - any in-flight operation is discarded.

## Timing
- **Request acceptance:** on the rising edge where `in_valid`&&`in_ready`. Call that edge E0.
- **BUSY occupancy:** edges E1..EN compute beats 0..N-1.
- **Result visibility:** `out_valid` rises after EN and is first visible in the cycle following EN.
  - Latency from the accept edge to `out_valid` high is N edges. WIDTH=32, CHUNK=8 → 4.
- **Return to IDLE:** the edge where `out_valid`&&`out_ready` moves the FSM to IDLE. `in_ready` is high in the following cycle.
- **Peak throughput:** one operation per N+2 cycles (N=4 → 6), with `in_valid` and `out_ready` held high.
- **Outputs:** all outputs are registered or decoded directly from state. There is no combinational path from any input to any output.

## Configuration
- **`ALU_LOGIC_ZFLAG_EN` defined:**
  - `zero` port exists. It is registered alongside `rd` and equals `(rd==0)`.
  - Reset value of `zero` is 1.
- **`ALU_LOGIC_ZFLAG_EN` undefined:**
  - `zero` port and its logic are absent.
  - All other behaviour and timing are identical.

## Test plan
- **Reset:** assert `rst` for 2 cycles during BUSY (after E2) → next cycle `in_ready`=1, `out_valid`=0, `rd`=0. A subsequent AND of 0xFFFFFFFF, 0x0F0F0F0F returns 0x0F0F0F0F.
- **AND table:** for each pair {0,0}, {0,0xFFFFFFFF}, {0xFFFFFFFF,0}, {0xFFFFFFFF,0xFFFFFFFF} with op=00 → `rd` = 0, 0, 0, 0xFFFFFFFF. `out_valid` rises exactly 4 edges after accept.
- **All ops:** rs1=0x12345678, rs2=0x0F0F00FF.
  - AND → 0x02040078
  - OR → 0x1F3F56FF
  - XOR → 0x1D3B5687
  - NOR → 0xE0C0A900
  - With the macro defined, `zero`=0 for each.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE → `rd` and `out_valid` stable, `in_ready`=0, and a request offered with `in_valid`=1 is not captured. Raise `out_ready` → IDLE next cycle, then the request is captured.
- **Operand isolation:** change `rs1`, `rs2` and `op` every cycle during BUSY → result reflects only the values captured at E0. `rd` holds the previous result until DONE.
- **Parameter sweep:** WIDTH=32 with CHUNK=32 and CHUNK=1, op=11, rs1=rs2=0 → `rd`=0xFFFFFFFF after 1 and 32 edges respectively (`zero`=0). With XOR of equal operands 0xA5A5A5A5 → `rd`=0, `zero`=1.

Source files
------------

// File: rtl/alu_logic_seq_if.sv
// alu_logic_seq_if -- request/response bundle for alu_logic_seq.
//   Request  : in_valid, in_ready, op[1:0], rs1, rs2
//   Response : out_valid, out_ready, rd, zero (zero only with ALU_LOGIC_ZFLAG_EN)
//   master modport = producer/consumer side, slave modport = the logic unit.
//   WIDTH must match the WIDTH of the alu_logic_seq it connects to.
interface alu_logic_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rd;
`ifdef ALU_LOGIC_ZFLAG_EN
    logic             zero;
`endif

    modport master (
        output in_valid, op, rs1, rs2, out_ready,
        input  in_ready, out_valid, rd
`ifdef ALU_LOGIC_ZFLAG_EN
        , input zero
`endif
    );

    modport slave (
        input  in_valid, op, rs1, rs2, out_ready,
        output in_ready, out_valid, rd
`ifdef ALU_LOGIC_ZFLAG_EN
        , output zero
`endif
    );
endinterface

// File: rtl/alu_logic_seq.sv
// alu_logic_seq -- multi-cycle bitwise logic unit (AND/OR/XOR/NOR).
//   Operands are captured on accept, then processed CHUNK bits per cycle,
//   LSB chunk first, for N = WIDTH/CHUNK beats. rd is loaded once, on the
//   last beat, and held until the next operation completes.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_logic_seq_if.slave (in_valid/in_ready/op/rs1/rs2,
//          out_valid/out_ready/rd[/zero])
// Parameters: WIDTH (operand width), CHUNK (bits per beat, WIDTH % CHUNK == 0).
// Optional: define ALU_LOGIC_ZFLAG_EN to add the registered zero flag.
module alu_logic_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic           clk,
    input logic           rst,
    alu_logic_seq_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [WIDTH-1:0] rd_q;
    logic [CHUNK-1:0] beat;
    logic             last;

    function automatic logic [CHUNK-1:0] logic_op(input logic [1:0]       o,
                                                  input logic [CHUNK-1:0] a,
                                                  input logic [CHUNK-1:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Current beat, and the accumulator with that beat merged in; the merged
    // value is what rd takes on the final beat, so no extra cycle is spent.
    always_comb begin
        beat   = logic_op(op_q, a_q[int'(cnt)*CHUNK +: CHUNK], b_q[int'(cnt)*CHUNK +: CHUNK]);
        acc_nx = acc;
        acc_nx[int'(cnt)*CHUNK +: CHUNK] = beat;
        last   = (cnt == CW'(N - 1));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nx = BUSY;
            BUSY:    if (last)          state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cnt   <= '0;
            acc   <= '0;
            rd_q  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_q  <= bus.rs1;
                    b_q  <= bus.rs2;
                    op_q <= bus.op;
                    cnt  <= '0;
                    acc  <= '0;
                end
                BUSY: begin
                    acc <= acc_nx;
                    cnt <= cnt + CW'(1);
                    if (last) rd_q <= acc_nx;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_LOGIC_ZFLAG_EN
    // Registered with rd so it never reflects a partial result.
    logic zero_q;
    always_ff @(posedge clk) begin
        if (rst)                        zero_q <= 1'b1;
        else if (state == BUSY && last) zero_q <= (acc_nx == '0);
    end
    assign bus.zero = zero_q;
`endif

    // Handshake outputs decode state only: no input-to-output path.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.rd        = rd_q;
endmodule

// File: tb/tb_alu_logic_seq.sv
// tb_alu_logic_seq -- self-checking bench for alu_logic_seq.
//   Three instances: CHUNK=8 (main), CHUNK=32 and CHUNK=1 (sweep).
//   Expected results come from a whole-word reference function.
module tb_alu_logic_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv [3];
    logic [1:0]  opv[3];
    logic [31:0] r1 [3];
    logic [31:0] r2 [3];
    logic        orv[3];
    logic        ir [3];
    logic        ov [3];
    logic [31:0] rdw[3];
`ifdef ALU_LOGIC_ZFLAG_EN
    logic        zr [3];
`endif
    logic [31:0] prev[3];
    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : gd
        localparam int CH = (g == 0) ? 8 : (g == 1) ? 32 : 1;
        alu_logic_seq_if #(.WIDTH(32)) bus ();
        assign bus.in_valid  = iv[g];
        assign bus.op        = opv[g];
        assign bus.rs1       = r1[g];
        assign bus.rs2       = r2[g];
        assign bus.out_ready = orv[g];
        assign ir[g]         = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign rdw[g]        = bus.rd;
`ifdef ALU_LOGIC_ZFLAG_EN
        assign zr[g]         = bus.zero;
`endif
        alu_logic_seq #(.WIDTH(32), .CHUNK(CH)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic int lat_of(input int s);
        return (s == 0) ? 4 : (s == 1) ? 1 : 32;
    endfunction

    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int s, input logic [31:0] exp_rd);
        chk("in_ready", 32'(ir[s]), 32'd1);
        chk("out_valid", 32'(ov[s]), 32'd0);
        chk("rd_idle", rdw[s], exp_rd);
`ifdef ALU_LOGIC_ZFLAG_EN
        chk("zero_idle", 32'(zr[s]), 32'(exp_rd == 32'd0));
`endif
    endtask

    // Present a request while the unit is IDLE; returns #1 after the accept edge.
    task automatic issue(input int s, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        opv[s] = o; r1[s] = a; r2[s] = b; iv[s] = 1'b1;
        @(posedge clk); #1;
    endtask

    // Count edges to out_valid, checking rd holds its old value meanwhile.
    // in_valid stays high through BUSY to show it is ignored there.
    task automatic wait_result(input int s, input logic [31:0] exp,
                               input logic [31:0] old, input bit scr);
        int  k    = 0;
        bit  seen = 1'b0;
        while (!seen && k < 100) begin
            if (scr) begin
                r1[s] = $urandom; r2[s] = $urandom; opv[s] = 2'($urandom);
            end
            @(posedge clk); #1; k++;
            if (ov[s]) seen = 1'b1;
            else chk("rd_hold", rdw[s], old);
        end
        iv[s] = 1'b0;
        chk("latency", seen ? 32'(k) : 32'd0, 32'(lat_of(s)));
        chk("rd", rdw[s], exp);
`ifdef ALU_LOGIC_ZFLAG_EN
        chk("zero", 32'(zr[s]), 32'(exp == 32'd0));
`endif
        if (orv[s]) begin
            @(posedge clk); #1;
            chk("in_ready_after", 32'(ir[s]), 32'd1);
            chk("out_valid_after", 32'(ov[s]), 32'd0);
        end
    endtask

    task automatic run_op(input int s, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit scr);
        logic [31:0] exp;
        exp = ref_op(o, a, b);
        issue(s, o, a, b);
        wait_result(s, exp, prev[s], scr);
        prev[s] = exp;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, e1, e2;
        for (int s = 0; s < 3; s++) begin
            iv[s] = 0; opv[s] = 0; r1[s] = 0; r2[s] = 0; orv[s] = 1; prev[s] = 0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 3; s++) chk_idle(s, 32'd0);

        // AND truth table on full words
        run_op(0, 2'b00, 32'h0000_0000, 32'h0000_0000, 0);
        run_op(0, 2'b00, 32'h0000_0000, 32'hFFFF_FFFF, 0);
        run_op(0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // every op on a mixed pattern
        for (int o = 0; o < 4; o++) run_op(0, 2'(o), 32'h1234_5678, 32'h0F0F_00FF, 0);

        // random operands, inputs scrambled every BUSY cycle
        for (int i = 0; i < 16; i++) run_op(0, 2'($urandom), $urandom, $urandom, 1);

        // backpressure: result held in DONE, offered request not taken
        orv[0] = 1'b0;
        e1 = ref_op(2'b10, 32'hCAFE_F00D, 32'h0123_4567);
        issue(0, 2'b10, 32'hCAFE_F00D, 32'h0123_4567);
        wait_result(0, e1, prev[0], 0);
        a = 32'h5555_AAAA; b = 32'h0F0F_3C3C;
        e2 = ref_op(2'b01, a, b);
        opv[0] = 2'b01; r1[0] = a; r2[0] = b; iv[0] = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(ov[0]), 32'd1);
            chk("bp_in_ready", 32'(ir[0]), 32'd0);
            chk("bp_rd", rdw[0], e1);
        end
        orv[0] = 1'b1;
        @(posedge clk); #1;
        chk_idle(0, e1);
        @(posedge clk); #1;
        wait_result(0, e2, e1, 0);
        prev[0] = e2;

        // reset two cycles long, landing mid-BUSY after E2
        issue(0, 2'b10, 32'hDEAD_BEEF, 32'h1234_5678);
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_idle(0, 32'd0);
        prev[0] = 32'd0;
        run_op(0, 2'b00, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 0);

        // chunk-size sweep
        for (int s = 1; s < 3; s++) begin
            run_op(s, 2'b11, 32'h0, 32'h0, 0);
            run_op(s, 2'b10, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
            for (int i = 0; i < 3; i++) run_op(s, 2'($urandom), $urandom, $urandom, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
